// File: rtl/skolem_urem_search_if.sv
// skolem_urem_search_if: start/abort request, operands and result bundle for the witness search
interface skolem_urem_search_if #(parameter int W = 4);
    logic         start;
    logic         abort;
    logic [1:0]   mode;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         ready;
    logic         done;
    logic         found;
    logic [W-1:0] x;
    modport master (output start, abort, mode, s, t, input ready, done, found, x);
    modport slave (input start, abort, mode, s, t, output ready, done, found, x);
endinterface

// File: rtl/skolem_urem_search.sv
// skolem_urem_search: smallest x with (x urem s | s urem x) <u / >u t, via a bit-serial restoring divider
module skolem_urem_search #(parameter int W = 4) (
    input logic clk,
    input logic rst_n,
    skolem_urem_search_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, DIV, CHECK, DONE} state_t;
    localparam int CW = $clog2(W + 1);
    state_t       state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic [W-1:0] s_q, s_d, t_q, t_d, b_q, b_d, q_q, q_d, x_q, x_d;
    logic [W:0]   c_q, c_d, r_q, r_d;
    logic [CW-1:0] n_q, n_d;
    logic         found_q, found_d;
    logic [W:0]   rs, diff;
    logic [W-1:0] rem;
    logic         pass, last, busy;
    always_comb begin
        rs   = {r_q[W-1:0], q_q[W-1]};
        diff = rs - {1'b0, b_q};
        rem  = r_q[W-1:0];
        pass = mode_q[1] ? (rem > t_q) : (rem < t_q);
        last = c_q == {1'b0, {W{1'b1}}};
        busy = state_q == LOAD || state_q == DIV || state_q == CHECK;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            s_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            x_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            n_q     <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
            t_q     <= t_d;
            b_q     <= b_d;
            q_q     <= q_d;
            x_q     <= x_d;
            c_q     <= c_d;
            r_q     <= r_d;
            n_q     <= n_d;
            found_q <= found_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? LOAD : IDLE;
            LOAD:    state_d = bus.abort ? IDLE : DIV;
            DIV:     state_d = bus.abort ? IDLE : (n_q == CW'(W - 1) ? CHECK : DIV);
            CHECK:   state_d = bus.abort ? IDLE : ((pass || last) ? DONE : LOAD);
            default: state_d = IDLE;
        endcase
    end
    // With a zero divisor nothing is ever subtracted, so r ends up equal to the dividend (a urem 0 = a)
    always_comb begin
        mode_d  = mode_q;
        s_d     = s_q;
        t_d     = t_q;
        b_d     = b_q;
        q_d     = q_q;
        x_d     = x_q;
        c_d     = c_q;
        r_d     = r_q;
        n_d     = n_q;
        found_d = found_q;
        if (state_q == IDLE && bus.start) begin
            mode_d  = bus.mode;
            s_d     = bus.s;
            t_d     = bus.t;
            c_d     = '0;
            x_d     = '0;
            found_d = 1'b0;
        end
        if (state_q == LOAD) begin
            b_d = mode_q[0] ? c_q[W-1:0] : s_q;
            q_d = mode_q[0] ? s_q : c_q[W-1:0];
            r_d = '0;
            n_d = '0;
        end
        if (state_q == DIV) begin
            r_d = diff[W] ? rs : diff;
            q_d = {q_q[W-2:0], ~diff[W]};
            n_d = n_q + CW'(1);
        end
        if (state_q == CHECK && !bus.abort) begin
            x_d     = pass ? c_q[W-1:0] : '0;
            found_d = pass;
            c_d     = (pass || last) ? c_q : c_q + (W + 1)'(1);
        end
        if (busy && bus.abort) begin
            x_d     = '0;
            found_d = 1'b0;
        end
    end
    always_comb begin
        bus.ready = state_q == IDLE;
        bus.done  = state_q == DONE;
        bus.found = found_q;
        bus.x     = x_q;
    end
endmodule

// File: tb/tb_skolem_urem_search.sv
// tb_skolem_urem_search: directed scenarios with hand-computed witnesses and done-cycle timing at W=4
module tb_skolem_urem_search;
    logic clk;
    logic rst_n;
    int n_checks;
    int n_fail;
    skolem_urem_search_if #(.W(4)) bus();
    skolem_urem_search #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic launch(input logic [1:0] m, input logic [3:0] sv, input logic [3:0] tv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.s     = sv;
        bus.t     = tv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.found !== 1'b0 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b done=%b found=%b x=%0d, expected 1 0 0 0", bus.ready, bus.done, bus.found, bus.x);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_trivial;
        int cyc;
        launch(2'b00, 4'd5, 4'd3);
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL trivial_busy: ready=%b expected 0", bus.ready);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 7 || bus.found !== 1'b1 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL trivial: cycle=%0d found=%b x=%0d, expected 7 1 0", cyc, bus.found, bus.x);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        launch(2'b01, 4'd7, 4'd1);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 13 || bus.found !== 1'b1 || bus.x !== 4'd1) begin
            n_fail++;
            $display("FAIL div_zero_s7: cycle=%0d found=%b x=%0d, expected 13 1 1", cyc, bus.found, bus.x);
        end
        launch(2'b01, 4'd9, 4'd10);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 7 || bus.found !== 1'b1 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL div_zero_s9: cycle=%0d found=%b x=%0d, expected 7 1 0", cyc, bus.found, bus.x);
        end
    endtask

    task automatic test_ugt;
        int cyc;
        launch(2'b10, 4'd5, 4'd3);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 31 || bus.found !== 1'b1 || bus.x !== 4'd4) begin
            n_fail++;
            $display("FAIL ugt: cycle=%0d found=%b x=%0d, expected 31 1 4", cyc, bus.found, bus.x);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.found !== 1'b1 || bus.x !== 4'd4) begin
            n_fail++;
            $display("FAIL ugt_hold: ready=%b done=%b found=%b x=%0d, expected 1 0 1 4", bus.ready, bus.done, bus.found, bus.x);
        end
    endtask

    task automatic test_exhaust;
        int cyc;
        int extra;
        launch(2'b00, 4'd5, 4'd0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 97 || bus.found !== 1'b0 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL exhaust: cycle=%0d found=%b x=%0d, expected 97 0 0", cyc, bus.found, bus.x);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        n_checks++;
        if (extra !== 0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL exhaust_wrap: extra_done=%0d ready=%b, expected 0 1", extra, bus.ready);
        end
        launch(2'b11, 4'd3, 4'd3);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 97 || bus.found !== 1'b0 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL exhaust_m11: cycle=%0d found=%b x=%0d, expected 97 0 0", cyc, bus.found, bus.x);
        end
    endtask

    task automatic test_abort;
        int cyc;
        int seen;
        launch(2'b00, 4'd5, 4'd0);
        cyc = 1;
        seen = 0;
        while (cyc < 41) begin
            bus.start = (cyc == 20);
            bus.abort = (cyc == 40);
            if (bus.done) seen++;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_checks++;
        if (seen !== 0 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.found !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: done_seen=%0d ready=%b done=%b found=%b, expected 0 1 0 0", seen, bus.ready, bus.done, bus.found);
        end
        repeat (80) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: done_seen=%0d expected 0", seen);
        end
        launch(2'b00, 4'd5, 4'd3);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 7 || bus.found !== 1'b1 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL after_abort: cycle=%0d found=%b x=%0d, expected 7 1 0", cyc, bus.found, bus.x);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(2'b00, 4'd5, 4'd3);
        wait_done(cyc);
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: ready=%b expected 1", bus.ready);
        end
        bus.start = 1'b1;
        bus.mode  = 2'b10;
        bus.s     = 4'd5;
        bus.t     = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc !== 31 || bus.found !== 1'b1 || bus.x !== 4'd4) begin
            n_fail++;
            $display("FAIL b2b: cycle=%0d found=%b x=%0d, expected 31 1 4", cyc, bus.found, bus.x);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.found !== 1'b0 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_idle: found=%b x=%0d, expected 0 0", bus.found, bus.x);
        end
        rst_n = 1'b1;
        launch(2'b10, 4'd5, 4'd3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.found !== 1'b0 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_div: ready=%b done=%b found=%b x=%0d, expected 1 0 0 0", bus.ready, bus.done, bus.found, bus.x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(2'b00, 4'd5, 4'd3);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 7 || bus.found !== 1'b1 || bus.x !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_rerun: cycle=%0d found=%b x=%0d, expected 7 1 0", cyc, bus.found, bus.x);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 2'b00;
        bus.s     = 4'd0;
        bus.t     = 4'd0;
        test_reset;
        test_trivial;
        test_div_zero;
        test_ugt;
        test_exhaust;
        test_abort;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
